proc_run_ctrl: RTL and testbench

//  Run controller and monitor for the multicycle top_proc.
//  - Sequences processor reset and run; detects program end.
//  - Counts cycles, retired instructions and stores; folds stores into a checksum.
//  - Replaces fixed-time bench runs with a deterministic done/halt_reason handshake.
//  - Sits beside top_proc / INSTRUCTION_MEMORY / DATA_MEMORY in system and bench tops.

---
 rtl/proc_run_ctrl_pkg.sv | 22 ++
 rtl/proc_run_ctrl_if.sv | 15 +
 rtl/proc_run_ctrl_run_checksum.sv | 27 ++
 rtl/proc_run_ctrl.sv | 126 ++++++++++++
 tb/tb_proc_run_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/proc_run_ctrl_pkg.sv
// Shared state encodings, halt codes and the address half-swap used by the
// store checksum of the proc_run_ctrl run controller.
package proc_run_ctrl_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] halt_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RSTP = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam halt_t HALT_NONE    = 2'd0;
    localparam halt_t HALT_END     = 2'd1;
    localparam halt_t HALT_LOOP    = 2'd2;
    localparam halt_t HALT_TIMEOUT = 2'd3;

    function automatic logic [31:0] swap_halves(input logic [31:0] v);
        return {v[15:0], v[31:16]};
    endfunction

endpackage

// File: rtl/proc_run_ctrl_if.sv
// Processor-side bundle watched by the run controller: PC, store bus and
// the reset the controller hands back to the processor.
interface proc_run_ctrl_if;

    logic [31:0] PC;
    logic        MemWrite;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic        cpu_rst;

    // master = processor side, slave = run controller
    modport master (output PC, MemWrite, dAddress, dWriteData, input cpu_rst);
    modport slave  (input PC, MemWrite, dAddress, dWriteData, output cpu_rst);

endinterface

// File: rtl/proc_run_ctrl_run_checksum.sv
// Rotate-left-by-one / XOR accumulator folding each observed store
// (data and half-swapped address) into a running checksum.
module run_checksum
    import proc_run_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [31:0]      addr,
    input  logic [31:0]      data,
    output logic [CNT_W-1:0] csum
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            csum <= '0;
        end else if (en) begin
            csum <= {csum[CNT_W-2:0], csum[CNT_W-1]}
                    ^ CNT_W'(data)
                    ^ CNT_W'(swap_halves(addr));
        end
    end

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller for the multicycle processor: sequences its reset, watches
// PC and stores during a run, and reports a registered done/halt_reason.
module proc_run_ctrl
    import proc_run_ctrl_pkg::*;
#(
    parameter int unsigned PROG_BYTES  = 512,
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned STALL_LIMIT = 16,
    parameter int unsigned MAX_CYCLES  = 4096,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    proc_run_ctrl_if.slave   cpu,
    output logic             running,
    output logic             done,
    output logic [1:0]       halt_reason,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] store_count,
    output logic [CNT_W-1:0] store_csum
);

    state_t      state;
    logic [31:0] rst_cnt;
    logic [31:0] pc_q;
    logic [31:0] stall_cnt;
    logic        first_cyc;

    logic        in_run;
    logic        start_ok;
    logic        pc_same;
    logic        pc_moved;
    halt_t       reason;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Halt sources are judged on this cycle's PC against the previous one;
    // the first RUN cycle has no valid previous PC.
    always_comb begin
        in_run   = (state == ST_RUN);
        start_ok = start && (state == ST_IDLE || state == ST_DONE);
        pc_same  = (cpu.PC == pc_q);
        pc_moved = !first_cyc && !pc_same;
        reason   = HALT_NONE;
        if (cpu.PC >= PROG_BYTES)
            reason = HALT_END;
        else if (!first_cyc && pc_same && stall_cnt == STALL_LIMIT - 1)
            reason = HALT_LOOP;
        else if (cycle_count == CNT_W'(MAX_CYCLES - 1))
            reason = HALT_TIMEOUT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rst_cnt     <= '0;
            pc_q        <= '0;
            stall_cnt   <= '0;
            first_cyc   <= 1'b1;
            cycle_count <= '0;
            instr_count <= '0;
            store_count <= '0;
            done        <= 1'b0;
            halt_reason <= HALT_NONE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state       <= ST_RSTP;
                        rst_cnt     <= '0;
                        stall_cnt   <= '0;
                        first_cyc   <= 1'b1;
                        cycle_count <= '0;
                        instr_count <= '0;
                        store_count <= '0;
                        done        <= 1'b0;
                        halt_reason <= HALT_NONE;
                    end
                end
                ST_RSTP: begin
                    if (rst_cnt == RST_CYCLES - 1)
                        state <= ST_RUN;
                    else
                        rst_cnt <= rst_cnt + 32'd1;
                end
                ST_RUN: begin
                    cycle_count <= sat_inc(cycle_count);
                    pc_q        <= cpu.PC;
                    first_cyc   <= 1'b0;
                    if (pc_moved) begin
                        instr_count <= sat_inc(instr_count);
                        stall_cnt   <= '0;
                    end else if (!first_cyc) begin
                        stall_cnt <= stall_cnt + 32'd1;
                    end
                    if (cpu.MemWrite)
                        store_count <= sat_inc(store_count);
                    if (reason != HALT_NONE) begin
                        state       <= ST_DONE;
                        done        <= 1'b1;
                        halt_reason <= reason;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign running     = in_run;
    assign cpu.cpu_rst = (state == ST_IDLE) || (state == ST_RSTP);

    run_checksum #(.CNT_W(CNT_W)) u_csum (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_ok),
        .en   (in_run && cpu.MemWrite),
        .addr (cpu.dAddress),
        .data (cpu.dWriteData),
        .csum (store_csum)
    );

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl: table of whole runs plus hand sequences
// for reset/start corner cases; instance 1 uses a 100-cycle budget.
module tb_proc_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] pc;
    logic        mw;
    logic [31:0] addr;
    logic [31:0] data;

    always #5 clk = ~clk;

    proc_run_ctrl_if bus_a ();
    proc_run_ctrl_if bus_b ();

    assign bus_a.PC = pc;  assign bus_a.MemWrite = mw;
    assign bus_a.dAddress = addr;  assign bus_a.dWriteData = data;
    assign bus_b.PC = pc;  assign bus_b.MemWrite = mw;
    assign bus_b.dAddress = addr;  assign bus_b.dWriteData = data;

    logic        running_v [2];
    logic        done_v    [2];
    logic [1:0]  reason_v  [2];
    logic [31:0] cyc_v     [2];
    logic [31:0] ins_v     [2];
    logic [31:0] st_v      [2];
    logic [31:0] cs_v      [2];
    logic        crst_v    [2];

    assign crst_v[0] = bus_a.cpu_rst;
    assign crst_v[1] = bus_b.cpu_rst;

    proc_run_ctrl u_dut_a (
        .clk(clk), .rst(rst), .start(start), .cpu(bus_a.slave),
        .running(running_v[0]), .done(done_v[0]), .halt_reason(reason_v[0]),
        .cycle_count(cyc_v[0]), .instr_count(ins_v[0]),
        .store_count(st_v[0]), .store_csum(cs_v[0])
    );

    proc_run_ctrl #(.MAX_CYCLES(100)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .cpu(bus_b.slave),
        .running(running_v[1]), .done(done_v[1]), .halt_reason(reason_v[1]),
        .cycle_count(cyc_v[1]), .instr_count(ins_v[1]),
        .store_count(st_v[1]), .store_csum(cs_v[1])
    );

    typedef struct {
        int unsigned mode;
        int unsigned inst;
        int unsigned halt_k;
        logic [1:0]  reason;
        logic [31:0] cyc;
        logic [31:0] ins;
        logic [31:0] st;
        logic [31:0] csum;
    } vec_t;

    vec_t vecs [6];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // PC seen in RUN cycle k (k starts at 1) for each stimulus pattern
    function automatic logic [31:0] pc_for(input int unsigned mode, input int unsigned k);
        case (mode)
            0: return 32'(4 * ((k - 1) / 5));
            1: return (k <= 11) ? 32'(32'h18 + 4 * (k - 1)) : 32'h40;
            2: return 32'(4 * ((k - 1) % 2));
            3: return (k == 100) ? 32'd512 : 32'(4 * ((k - 1) % 2));
            4: return 32'(4 * (k - 1));
            default: return 32'h200;
        endcase
    endfunction

    task automatic do_reset;
        rst = 1'b1; start = 1'b0; mw = 1'b0; pc = '0; addr = '0; data = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_run(input int unsigned i);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rstp_cpu_rst", 32'(crst_v[i]), 32'd1);
        @(negedge clk);
        check("rstp_running", 32'(running_v[i]), 32'd0);
        @(negedge clk);
        check("run_cpu_rst", 32'(crst_v[i]), 32'd0);
        check("run_running", 32'(running_v[i]), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected bench end");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned found;

        vecs[0] = '{0, 0, 641, 2'd1, 641, 128, 0, 32'h0};
        vecs[1] = '{1, 0,  27, 2'd2,  27,  10, 0, 32'h0};
        vecs[2] = '{2, 1, 100, 2'd3, 100,  99, 0, 32'h0};
        vecs[3] = '{3, 1, 100, 2'd1, 100,  99, 0, 32'h0};
        vecs[4] = '{4, 0, 129, 2'd1, 129, 128, 2, 32'hBD6F7DDE};
        vecs[5] = '{5, 0,   1, 2'd1,   1,   0, 0, 32'h0};

        rst = 1'b1; start = 1'b0; mw = 1'b0; pc = '0; addr = '0; data = '0;
        repeat (3) @(negedge clk);
        check("rst_cpu_rst", 32'(crst_v[0]), 32'd1);
        check("rst_running", 32'(running_v[0]), 32'd0);
        check("rst_done", 32'(done_v[0]), 32'd0);
        check("rst_reason", 32'(reason_v[0]), 32'd0);
        check("rst_counts", cyc_v[0] | ins_v[0] | st_v[0] | cs_v[0], 32'd0);
        check("rst_cpu_rst_b", 32'(crst_v[1]), 32'd1);

        for (int v = 0; v < 6; v++) begin
            int unsigned i;
            i = vecs[v].inst;
            do_reset();
            if (vecs[v].mode == 4) begin
                // stores outside RUN must be ignored
                mw = 1'b1; addr = 32'h99; data = 32'h1234;
            end
            start_run(i);
            found = 0;
            for (int unsigned k = 1; k <= vecs[v].halt_k + 20; k++) begin
                pc   = pc_for(vecs[v].mode, k);
                mw   = (vecs[v].mode == 4) && (k == 3 || k == 5);
                addr = (k == 3) ? 32'h10 : 32'h14;
                data = (k == 3) ? 32'hDEADBEEF : 32'h1;
                @(negedge clk);
                if (done_v[i]) begin
                    found = k;
                    break;
                end
            end
            mw = 1'b0;
            check($sformatf("v%0d_halt_k", v), found, vecs[v].halt_k);
            check($sformatf("v%0d_reason", v), 32'(reason_v[i]), 32'(vecs[v].reason));
            check($sformatf("v%0d_cycles", v), cyc_v[i], vecs[v].cyc);
            check($sformatf("v%0d_instr", v), ins_v[i], vecs[v].ins);
            check($sformatf("v%0d_stores", v), st_v[i], vecs[v].st);
            check($sformatf("v%0d_csum", v), cs_v[i], vecs[v].csum);
            check($sformatf("v%0d_running", v), 32'(running_v[i]), 32'd0);
        end

        // start during RUN is ignored; rst mid-RUN returns to IDLE
        do_reset();
        start_run(0);
        for (int unsigned k = 1; k <= 10; k++) begin
            pc = pc_for(2, k);
            start = (k == 5);
            @(negedge clk);
            if (k == 5) begin
                check("srun_running", 32'(running_v[0]), 32'd1);
                check("srun_cycles", cyc_v[0], 32'd5);
            end
        end
        start = 1'b0;
        check("midrun_instr", ins_v[0], 32'd9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_cpu_rst", 32'(crst_v[0]), 32'd1);
        check("midrst_running", 32'(running_v[0]), 32'd0);
        check("midrst_cycles", cyc_v[0], 32'd0);
        repeat (2) @(negedge clk);
        check("idle_cpu_rst", 32'(crst_v[0]), 32'd1);
        check("idle_running", 32'(running_v[0]), 32'd0);

        // DONE holds outputs; start from DONE clears and reruns
        do_reset();
        start_run(0);
        pc = 32'h200;
        @(negedge clk);
        check("d_done", 32'(done_v[0]), 32'd1);
        pc = 32'h0;
        repeat (3) @(negedge clk);
        check("d_hold_done", 32'(done_v[0]), 32'd1);
        check("d_hold_cycles", cyc_v[0], 32'd1);
        check("d_hold_reason", 32'(reason_v[0]), 32'd1);
        check("d_cpu_rst", 32'(crst_v[0]), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_done", 32'(done_v[0]), 32'd0);
        check("restart_reason", 32'(reason_v[0]), 32'd0);
        check("restart_cycles", cyc_v[0], 32'd0);
        check("restart_cpu_rst", 32'(crst_v[0]), 32'd1);
        repeat (2) @(negedge clk);
        check("rerun_running", 32'(running_v[0]), 32'd1);
        pc = 32'h200;
        @(negedge clk);
        check("rerun_done", 32'(done_v[0]), 32'd1);
        check("rerun_reason", 32'(reason_v[0]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
